// File: rtl/bounce_generator.sv
// -----------------------------------------------------------------------------
// bounce_generator
//
// Contact-bounce emulator. It takes a clean, synchronous level and turns every
// level change into a burst of pseudo-random chatter. After a fixed window it
// settles to the new level. It is the transmit-side partner of a switch
// debouncer: bouncy_out can be looped straight into a debouncer's bouncy input
// for self-test or simulation.
//
// Parameters
//   BOUNCE_CYCLES : length of the chatter window in clk cycles, counted from
//                   the last clean_in change (>= 2)
//   MAX_GAP       : upper bound on cycles between chatter toggles
//                   (power of 2, >= 2)
//   LFSR_SEED     : reset value of the 16-bit LFSR (0 is replaced by 16'hACE1)
//
// Ports
//   clk        : system clock
//   rst        : synchronous, active-high reset
//   clean_in   : clean level to emulate (already synchronous to clk)
//   bouncy_out : registered, chattering emulated contact
//   busy       : registered, high while the chatter window is active
// -----------------------------------------------------------------------------
module bounce_generator #(
  parameter int          BOUNCE_CYCLES = 4096,
  parameter int          MAX_GAP       = 64,
  parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
  input  logic clk,
  input  logic rst,
  input  logic clean_in,
  output logic bouncy_out,
  output logic busy
);

  // ---------------------------------------------------------------------------
  // Derived constants
  // ---------------------------------------------------------------------------
  localparam int WIN_W = (BOUNCE_CYCLES > 2) ? $clog2(BOUNCE_CYCLES) : 1;
  localparam int GAP_W = $clog2(MAX_GAP) + 1;

  localparam logic [WIN_W-1:0] WIN_LOAD = WIN_W'(BOUNCE_CYCLES - 1);
  localparam logic [GAP_W-1:0] GAP_ONE  = GAP_W'(1);
  localparam logic [WIN_W-1:0] WIN_ONE  = WIN_W'(1);

  // An all-zero Galois LFSR would lock up, so a zero seed falls back to the
  // default seed.
  localparam logic [15:0] SEED_EFF = (LFSR_SEED == 16'h0000) ? 16'hACE1 : LFSR_SEED;

  // Feedback mask for x^16 + x^14 + x^13 + x^11 + 1 in the right-shifting
  // Galois form.
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  // ---------------------------------------------------------------------------
  // Elaboration-time parameter checks
  // ---------------------------------------------------------------------------
  generate
    if (BOUNCE_CYCLES < 2) begin : g_bad_bounce_cycles
      $error("bounce_generator: BOUNCE_CYCLES must be >= 2");
    end
    if ((MAX_GAP < 2) || ((MAX_GAP & (MAX_GAP - 1)) != 0)) begin : g_bad_max_gap
      $error("bounce_generator: MAX_GAP must be a power of 2 and >= 2");
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------------
  typedef enum logic {
    IDLE   = 1'b0,
    BOUNCE = 1'b1
  } state_t;

  state_t           state_reg,  state_next;
  logic             target_reg, target_next;
  logic             out_reg,    out_next;
  logic             busy_reg,   busy_next;
  logic [15:0]      lfsr_reg,   lfsr_next;
  logic [WIN_W-1:0] win_reg,    win_next;
  logic [GAP_W-1:0] gap_reg,    gap_next;

  // A clean_in level that differs from the current target starts a new window
  // (IDLE) or restarts the running one (BOUNCE).
  logic             level_change;
  logic [GAP_W-1:0] gap_new;

  assign level_change = (clean_in != target_reg);

  // The low log2(MAX_GAP) LFSR bits give a random gap of 1..MAX_GAP. The extra
  // counter bit lets MAX_GAP itself be represented.
  assign gap_new = {1'b0, lfsr_reg[GAP_W-2:0]} + GAP_ONE;

  // The LFSR runs free in every non-reset cycle, whatever the state. A nonzero
  // seed keeps it off the all-zero state for good.
  assign lfsr_next = {1'b0, lfsr_reg[15:1]} ^ (lfsr_reg[0] ? LFSR_TAPS : 16'h0000);

  // ---------------------------------------------------------------------------
  // Process 1: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= IDLE;
      target_reg <= 1'b0;
      out_reg    <= 1'b0;
      busy_reg   <= 1'b0;
      lfsr_reg   <= SEED_EFF;
      win_reg    <= '0;
      gap_reg    <= '0;
    end else begin
      state_reg  <= state_next;
      target_reg <= target_next;
      out_reg    <= out_next;
      busy_reg   <= busy_next;
      lfsr_reg   <= lfsr_next;
      win_reg    <= win_next;
      gap_reg    <= gap_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Process 2: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      IDLE: begin
        if (level_change) begin
          state_next = BOUNCE;
        end
      end
      BOUNCE: begin
        // A change on the same edge that the window runs out is a retarget.
        // The machine stays in BOUNCE.
        if (!level_change && (win_reg == '0)) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Process 3: output / datapath logic
  // ---------------------------------------------------------------------------
  always_comb begin
    target_next = target_reg;
    out_next    = out_reg;
    busy_next   = busy_reg;
    win_next    = win_reg;
    gap_next    = gap_reg;

    unique case (state_reg)
      IDLE: begin
        out_next  = target_reg;
        busy_next = 1'b0;
        if (level_change) begin
          // First contact follows the new level right away. Chatter starts
          // after the first random gap.
          target_next = clean_in;
          out_next    = clean_in;
          win_next    = WIN_LOAD;
          gap_next    = gap_new;
          busy_next   = 1'b1;
        end
      end

      BOUNCE: begin
        if (level_change) begin
          // Retarget: same actions as entry, and the window restarts in full.
          target_next = clean_in;
          out_next    = clean_in;
          win_next    = WIN_LOAD;
          gap_next    = gap_new;
          busy_next   = 1'b1;
        end else if (win_reg == '0) begin
          // The window has expired, so settle on the target level.
          out_next  = target_reg;
          busy_next = 1'b0;
        end else begin
          win_next = win_reg - WIN_ONE;
          if (gap_reg == GAP_ONE) begin
            out_next = ~out_reg;
            gap_next = gap_new;
          end else begin
            gap_next = gap_reg - GAP_ONE;
          end
        end
      end

      default: begin
        out_next  = target_reg;
        busy_next = 1'b0;
      end
    endcase
  end

  assign bouncy_out = out_reg;
  assign busy       = busy_reg;

endmodule

// File: tb/tb_bounce_generator.sv
// -----------------------------------------------------------------------------
// tb_bounce_generator
//
// Directed bench for bounce_generator with BOUNCE_CYCLES=16 and MAX_GAP=4.
// Each step drives clean_in/rst and checks the window timing, first contact,
// settling, retarget, reset mid-bounce and the boundary case. A cycle-level
// reference model runs next to the DUT so that the exact chatter sequence and
// the LFSR can be checked bit for bit.
// -----------------------------------------------------------------------------
module tb_bounce_generator;

  localparam int          BC   = 16;
  localparam int          MG   = 4;
  localparam logic [15:0] SEED = 16'hACE1;

  logic clk      = 1'b0;
  logic rst      = 1'b1;
  logic clean_in = 1'b0;
  logic bouncy_out;
  logic busy;

  always #10 clk = ~clk;

  bounce_generator #(
    .BOUNCE_CYCLES(BC),
    .MAX_GAP      (MG),
    .LFSR_SEED    (SEED)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .clean_in  (clean_in),
    .bouncy_out(bouncy_out),
    .busy      (busy)
  );

  int compared   = 0;
  int mismatched = 0;
  int cyc        = 0;

  // Reference model state
  logic [15:0] m_lfsr   = SEED;
  logic        m_target = 1'b0;
  logic        m_out    = 1'b0;
  logic        m_busy   = 1'b0;
  logic        m_bounce = 1'b0;
  int          m_win    = 0;
  int          m_gap    = 0;

  int model_err = 0;
  int lfsr_zero = 0;

  // Toggle / busy statistics for the current step
  logic prev_out  = 1'b0;
  int   toggles   = 0;
  int   last_tog  = -1;
  int   max_space = 0;
  int   busy_hi   = 0;

  // Galois step for x^16+x^14+x^13+x^11+1, written one tap at a time.
  function automatic logic [15:0] lfsr_adv(input logic [15:0] v);
    logic [15:0] n;
    n = v >> 1;
    if (v[0]) begin
      n[15] = ~n[15];
      n[13] = ~n[13];
      n[12] = ~n[12];
      n[10] = ~n[10];
    end
    return n;
  endfunction

  task automatic model_entry(input int gn);
    m_target = clean_in;
    m_out    = clean_in;
    m_win    = BC - 1;
    m_gap    = gn;
    m_busy   = 1'b1;
    m_bounce = 1'b1;
  endtask

  task automatic model_step();
    int gn;
    if (rst) begin
      m_lfsr = SEED; m_target = 1'b0; m_out = 1'b0; m_busy = 1'b0;
      m_bounce = 1'b0; m_win = 0; m_gap = 0;
    end else begin
      gn = int'(m_lfsr % MG) + 1;
      if (clean_in != m_target) begin
        model_entry(gn);
      end else if (m_bounce) begin
        if (m_win == 0) begin
          m_out = m_target; m_busy = 1'b0; m_bounce = 1'b0;
        end else begin
          m_win = m_win - 1;
          if (m_gap == 1) begin
            m_out = ~m_out;
            m_gap = gn;
          end else begin
            m_gap = m_gap - 1;
          end
        end
      end
      m_lfsr = lfsr_adv(m_lfsr);
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic clear_stats();
    toggles   = 0;
    last_tog  = -1;
    max_space = 0;
    busy_hi   = 0;
  endtask

  // One clock: the model updates at the edge, and the DUT is sampled 1 ns later.
  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    cyc++;
    if (bouncy_out !== m_out || busy !== m_busy || dut.lfsr_reg !== m_lfsr) model_err++;
    if (dut.lfsr_reg == 16'h0000) lfsr_zero++;
    if (bouncy_out !== prev_out) begin
      toggles++;
      if (last_tog >= 0 && (cyc - last_tog) > max_space) max_space = cyc - last_tog;
      last_tog = cyc;
    end
    prev_out = bouncy_out;
    if (busy) busy_hi++;
  endtask

  initial begin
    // 1. Reset, then idle
    rst = 1'b1; clean_in = 1'b0;
    repeat (3) tick();
    check("reset_out", bouncy_out, 0);
    check("reset_busy", busy, 0);
    rst = 1'b0;
    clear_stats();
    repeat (100) tick();
    check("idle_toggles", toggles, 0);
    check("idle_busy", busy_hi, 0);
    $display("step idle: toggles=%0d busy_cycles=%0d", toggles, busy_hi);

    // 2. Single rise
    clean_in = 1'b1;
    clear_stats();
    tick();                                   // N
    check("rise_first_out", bouncy_out, 1);
    check("rise_busy_N", busy, 1);
    repeat (15) tick();                       // N+15
    check("rise_busy_N15", busy, 1);
    check("rise_toggles_ge3", (toggles - 1) >= 3, 1);
    check("rise_max_gap", max_space <= MG, 1);
    $display("step rise: chatter toggles=%0d max spacing=%0d", toggles - 1, max_space);
    tick();                                   // N+16
    check("rise_settle_busy", busy, 0);
    check("rise_settle_out", bouncy_out, 1);
    clear_stats();
    repeat (200) tick();
    check("rise_stable_toggles", toggles, 0);
    check("rise_stable_busy", busy_hi, 0);

    // 3. Retarget mid-bounce
    clean_in = 1'b0;
    repeat (20) tick();
    clean_in = 1'b1;
    tick();                                   // N
    check("retgt_rise_out", bouncy_out, 1);
    repeat (6) tick();                        // N+6
    clean_in = 1'b0;
    tick();                                   // N+7
    check("retgt_fall_out", bouncy_out, 0);
    check("retgt_fall_busy", busy, 1);
    repeat (15) tick();                       // N+22
    check("retgt_busy_N22", busy, 1);
    tick();                                   // N+23
    check("retgt_settle_busy", busy, 0);
    check("retgt_settle_out", bouncy_out, 0);
    clear_stats();
    repeat (100) tick();
    check("retgt_stable_toggles", toggles, 0);
    $display("step retarget: settled out=%0d", bouncy_out);

    // 4. Reset mid-bounce
    clean_in = 1'b1;
    tick();                                   // N
    repeat (4) tick();                        // N+4
    rst = 1'b1;
    tick();                                   // N+5
    check("rstmid_out", bouncy_out, 0);
    check("rstmid_busy", busy, 0);
    rst = 1'b0;
    tick();                                   // N+6: fresh entry
    check("rstmid_reentry_out", bouncy_out, 1);
    check("rstmid_reentry_busy", busy, 1);
    repeat (15) tick();
    check("rstmid_busy_last", busy, 1);
    tick();
    check("rstmid_settle_busy", busy, 0);
    check("rstmid_settle_out", bouncy_out, 1);
    $display("step reset-mid-bounce: settled out=%0d", bouncy_out);

    // 5. Boundary retarget on the window==0 edge
    clean_in = 1'b0;
    tick();                                   // M
    repeat (15) tick();                       // M+15, window now 0
    check("bound_busy_M15", busy, 1);
    clean_in = 1'b1;
    tick();                                   // M+16: retarget, not settle
    check("bound_retgt_busy", busy, 1);
    check("bound_retgt_out", bouncy_out, 1);
    repeat (15) tick();                       // M+31
    check("bound_busy_M31", busy, 1);
    tick();                                   // M+32
    check("bound_settle_busy", busy, 0);
    check("bound_settle_out", bouncy_out, 1);
    $display("step boundary: settled out=%0d", bouncy_out);

    // 6. Single-cycle glitch in IDLE, ending at the original level
    clean_in = 1'b0;
    tick();                                   // P
    check("glitch_out", bouncy_out, 0);
    check("glitch_busy", busy, 1);
    clean_in = 1'b1;
    tick();                                   // P+1
    check("glitch_back_out", bouncy_out, 1);
    repeat (15) tick();
    check("glitch_busy_last", busy, 1);
    tick();
    check("glitch_settle_busy", busy, 0);
    check("glitch_settle_out", bouncy_out, 1);
    $display("step glitch: settled out=%0d", bouncy_out);

    // Full-run bit-exact agreement with the model, and the LFSR never at 0
    check("model_bit_exact", model_err, 0);
    check("lfsr_never_zero", lfsr_zero, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/bounce_generator.md
Name: bounce_generator

Overview:
- Synthesizable contact-bounce emulator: the transmit-side counterpart of the switch debouncer.
- Takes a clean, synchronous level and drives a pseudo-randomly chattering output on every level change, then settles to the new level after a fixed window.
- Used in on-FPGA self-test and in simulation loopback: bouncy_out feeds the debouncer's bouncy input, so debounce behaviour can be checked without physical switches.

Parameters:
- BOUNCE_CYCLES, 4096: length of the chatter window in clk cycles after the last clean_in change; legal range >= 2.
- MAX_GAP, 64: upper bound on cycles between consecutive chatter toggles; must be a power of 2, >= 2.
- LFSR_SEED, 16'hACE1: reset value of the 16-bit LFSR; a value of 0 is replaced by 16'hACE1.

Ports:
- clk  input  1  50MHz system clock
- rst  input  1  reset; synchronous to clk, active-high
- clean_in  input  1  clean level to emulate; synchronous to clk, no synchronizer applied
- bouncy_out  output  1  chattering emulated switch contact (registered)
- busy  output  1  high while the chatter window is active (registered)

Behaviour:
- Reset, sampled at posedge clk while rst=1:
  - bouncy_out=0, busy=0, target=0, state=IDLE, lfsr=LFSR_SEED.
  - window and gap counters=0.
  - rst overrides all other activity, including a reset mid-bounce: the next cycle is clean IDLE with output 0.
- LFSR:
  - 16-bit Galois LFSR, taps x^16+x^14+x^13+x^11+1.
  - Advances every non-reset cycle in both states.
  - Never holds 0.
- Gap value: gap_new = (lfsr & (MAX_GAP-1)) + 1, range 1..MAX_GAP. Counter width is log2(MAX_GAP)+1.
- Window counter width: clog2(BOUNCE_CYCLES).
- State IDLE:
  - bouncy_out == target, busy=0.
  - If clean_in != target at a posedge (call it cycle N), that posedge performs the entry actions:
    - target<=clean_in and bouncy_out<=clean_in (first contact, 1-cycle latency).
    - window<=BOUNCE_CYCLES-1, gap<=gap_new.
    - busy<=1, state<=BOUNCE.
- State BOUNCE, priority per posedge:
  1. clean_in != target: retarget. Perform the same actions as IDLE entry; the window restarts from full length.
  2. window==0: bouncy_out<=target, busy<=0, state<=IDLE.
  3. Otherwise window decrements, and:
     - if gap==1: bouncy_out<=~bouncy_out and gap<=gap_new;
     - else gap decrements.
- Timing guarantees, with no further clean_in change after cycle N:
  - busy is high for exactly BOUNCE_CYCLES cycles (posedges N..N+BOUNCE_CYCLES-1 show busy=1 afterwards).
  - bouncy_out == target from posedge N+BOUNCE_CYCLES onward.
  - No two toggles are more than MAX_GAP cycles apart during the window.
  - Toggles never occur outside the window.
- Simultaneous events:
  - A clean_in change on the same posedge that window reaches 0 is a retarget, not a settle.
  - A clean_in pulse that returns to the old level during BOUNCE retargets again. The output ends at the final clean_in level.
- clean_in glitch of a single cycle in IDLE: accepted as a real change and produces a full window. The block does not filter its input.
- The output sequence is fully deterministic for a given LFSR_SEED and clean_in stimulus. A cycle-accurate reference model must match it bit-for-bit.

Test Plan:
1. Reset then idle: rst high 3 cycles, clean_in=0 for 100 cycles -> bouncy_out=0 and busy=0 throughout; LFSR never 0.
2. Single rise, BOUNCE_CYCLES=16, MAX_GAP=4: clean_in 0->1 sampled at N ->
   - bouncy_out=1 after posedge N;
   - at least 3 toggles within N+1..N+15, no gap over 4 cycles;
   - bouncy_out=1 and busy=0 from posedge N+16, stable for 200 cycles.
3. Retarget mid-bounce: rise at N, fall at N+7 -> window restarts; bouncy_out=0 and busy=0 from posedge N+23; no toggles after that.
4. Reset mid-bounce: rst asserted at N+5 for 1 cycle -> bouncy_out=0, busy=0 the next cycle; clean_in=1 still present then triggers a fresh window.
5. Boundary retarget: clean_in change on the exact cycle window==0 -> busy stays high, and a new 16-cycle window runs.
6. Loopback with debouncer (counter settle 2^14 cycles), BOUNCE_CYCLES=4096: a 0->1->0 sequence with 40000-cycle holds -> the debouncer's clean output rises and falls once each, with no extra edges; the bit sequence matches the reference model.
